// File: rtl/m_loadstore.sv
// m_loadstore: MEM-stage load/store unit bridging the pipeline to a
// request/acknowledge word bus. Big-endian lane placement, zero-extended
// loads, lane-replicated stores, alignment check and ACCESS timeout.
module m_loadstore #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ls_valid,
    input  logic        i_ls_memread,
    input  logic        i_ls_memwrite,
    input  logic [1:0]  i_ls_loadsig,
    input  logic [1:0]  i_ls_storesz,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    output logic        o_ls_stall,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_rvalid,
    output logic        o_ls_misalign,
    output logic        o_ls_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Last counter value before the access is abandoned: req stays high
    // for exactly TIMEOUT ACCESS cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q, lsize_q;
    logic        rvalid_q, misalign_q, err_q;

    logic        is_req, is_wr, misal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, rd_extract;
    logic        accept, misal_evt, ack_evt, to_evt, stall;

    // Request decode: alignment, byte enables and replicated store data.
    always_comb begin
        is_req    = i_ls_valid & (i_ls_memread | i_ls_memwrite);
        is_wr     = i_ls_memwrite;
        misal     = 1'b0;
        be_new    = 4'b1111;
        wdata_new = '0;
        if (is_wr) begin
            case (i_ls_storesz)
                2'b00: begin
                    case (i_ls_addr[1:0])
                        2'b00:   be_new = 4'b1000;
                        2'b01:   be_new = 4'b0100;
                        2'b10:   be_new = 4'b0010;
                        default: be_new = 4'b0001;
                    endcase
                    wdata_new = {4{i_ls_wdata[7:0]}};
                end
                2'b01: begin
                    misal     = i_ls_addr[0];
                    be_new    = i_ls_addr[1] ? 4'b0011 : 4'b1100;
                    wdata_new = {2{i_ls_wdata[15:0]}};
                end
                default: begin
                    misal     = |i_ls_addr[1:0];
                    wdata_new = i_ls_wdata;
                end
            endcase
        end else begin
            case (i_ls_loadsig)
                2'b10:   misal = 1'b0;
                2'b01:   misal = i_ls_addr[0];
                default: misal = |i_ls_addr[1:0];
            endcase
        end
    end

    // Load data extraction from the returned bus word.
    always_comb begin
        rd_extract = i_mem_rdata;
        case (lsize_q)
            2'b10: begin
                case (off_q)
                    2'b00:   rd_extract = {24'b0, i_mem_rdata[31:24]};
                    2'b01:   rd_extract = {24'b0, i_mem_rdata[23:16]};
                    2'b10:   rd_extract = {24'b0, i_mem_rdata[15:8]};
                    default: rd_extract = {24'b0, i_mem_rdata[7:0]};
                endcase
            end
            2'b01: rd_extract = off_q[1] ? {16'b0, i_mem_rdata[15:0]}
                                         : {16'b0, i_mem_rdata[31:16]};
            default: rd_extract = i_mem_rdata;
        endcase
    end

    // FSM next state and event decode.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        misal_evt = 1'b0;
        ack_evt   = 1'b0;
        to_evt    = 1'b0;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_req) begin
                    if (misal) begin
                        misal_evt = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                stall = 1'b1;
                if (i_mem_ack) begin
                    ack_evt = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    to_evt  = 1'b1;
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Bus request registers, timeout counter and response pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            lsize_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            misalign_q <= misal_evt;
            err_q      <= to_evt;
            rvalid_q   <= ack_evt & ~we_q;
            if (accept) begin
                req_q   <= 1'b1;
                we_q    <= is_wr;
                addr_q  <= {i_ls_addr[31:2], 2'b00};
                be_q    <= be_new;
                wdata_q <= wdata_new;
                off_q   <= i_ls_addr[1:0];
                lsize_q <= i_ls_loadsig;
                cnt_q   <= '0;
            end
            if (state_q == S_ACCESS && !ack_evt && !to_evt) cnt_q <= cnt_q + 8'd1;
            if (ack_evt || to_evt) req_q <= 1'b0;
            if (ack_evt && !we_q) rdata_q <= rd_extract;
            if (to_evt) rdata_q <= '0;
        end
    end

    // Stall is combinational so the pipeline freezes in the request cycle;
    // gated by reset so it drops asynchronously.
    assign o_ls_stall    = stall & ~i_rst;
    assign o_ls_rdata    = rdata_q;
    assign o_ls_rvalid   = rvalid_q;
    assign o_ls_misalign = misalign_q;
    assign o_ls_err      = err_q;
    assign o_mem_req     = req_q;
    assign o_mem_we      = we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_be      = be_q;
    assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_m_loadstore.sv
// Scoreboard bench for m_loadstore: stimulus pushes expected pulses and bus
// transfers into queues, monitors pop and compare as the DUT presents them.
module tb_m_loadstore;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ls_valid = 1'b0, ls_memread = 1'b0, ls_memwrite = 1'b0;
    logic [1:0]  ls_loadsig = '0, ls_storesz = '0;
    logic [31:0] ls_addr = '0, ls_wdata = '0;
    logic        ls_stall, ls_rvalid, ls_misalign, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    m_loadstore #(.TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ls_valid(ls_valid), .i_ls_memread(ls_memread), .i_ls_memwrite(ls_memwrite),
        .i_ls_loadsig(ls_loadsig), .i_ls_storesz(ls_storesz),
        .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .o_ls_stall(ls_stall), .o_ls_rdata(ls_rdata), .o_ls_rvalid(ls_rvalid),
        .o_ls_misalign(ls_misalign), .o_ls_err(ls_err),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] kind; logic [31:0] data; int cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    ack_wait = -1;
    int    acnt     = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus responder: ack after ack_wait ACCESS cycles; ack_wait<0 never acks.
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_req) begin
            mem_ack = (ack_wait >= 0) && (acnt >= ack_wait);
            acnt++;
        end else begin
            mem_ack = 1'b0;
            acnt = 0;
        end
    end

    // Response monitor: {rvalid, misalign, err} pulses.
    initial forever begin
        @(negedge clk);
        if (ls_rvalid || ls_misalign || ls_err) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_pulse", {29'b0, ls_rvalid, ls_misalign, ls_err}, 32'h0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("pulse_kind", {29'b0, ls_rvalid, ls_misalign, ls_err}, {29'b0, e.kind});
                chk("pulse_cycle", cyc, e.cyc);
                if (e.kind != 3'b010) chk("rdata", ls_rdata, e.data);
            end
        end
    end

    // Bus monitor: compare the transfer at the acked cycle.
    initial forever begin
        @(negedge clk);
        if (mem_req && mem_ack) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus", 32'h1, 32'h0);
            end else begin
                bus_t b;
                b = bus_q.pop_front();
                chk("mem_addr", mem_addr, b.addr);
                chk("mem_we", {31'b0, mem_we}, {31'b0, b.we});
                chk("mem_be", {28'b0, mem_be}, {28'b0, b.be});
                chk("mem_wdata", mem_wdata, b.wdata);
            end
        end
    end

    // One request: rk = expected pulse ({rvalid,misalign,err}, 0 = none)
    // at rlat cycles after the request cycle; stall_n = stalled cycles.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] lsig,
                         input logic [1:0] ssz, input logic [31:0] addr,
                         input logic [31:0] wd, input int w,
                         input logic [2:0] rk, input logic [31:0] rexp, input int rlat,
                         input logic bexp, input logic [3:0] bbe, input logic [31:0] bwd,
                         input int stall_n);
        int n;
        bit done;
        @(posedge clk);
        #1;
        ls_valid = 1'b1; ls_memread = rd; ls_memwrite = wr;
        ls_loadsig = lsig; ls_storesz = ssz; ls_addr = addr; ls_wdata = wd;
        ack_wait = w;
        if (rk != 3'b000) resp_q.push_back('{rk, rexp, cyc + rlat});
        if (bexp) bus_q.push_back('{{addr[31:2], 2'b00}, wr, bbe, bwd});
        #1;
        n = ls_stall ? 1 : 0;
        @(posedge clk);
        #1;
        ls_valid = 1'b0; ls_memread = 1'b0; ls_memwrite = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!ls_stall) done = 1'b1;
            else n++;
        end
        if (!done) chk("stall_timeout", 32'h1, 32'h0);
        chk("stall_cycles", n, stall_n);
        if (stall_n == 0) chk("no_req_on_misalign", {31'b0, mem_req}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_rdata = 32'hAABBCCDD;
        #2;
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_stall", {31'b0, ls_stall}, 32'h0);
        chk("rst_pulses", {29'b0, ls_rvalid, ls_misalign, ls_err}, 32'h0);
        chk("rst_rdata", ls_rdata, 32'h0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        //     rd wr lsig  ssz   addr          wdata         w   kind    rexp          lat bus be      bwdata        stall
        issue(1, 0, 2'b10, 2'b00, 32'h0000_1001, 32'h0,        0, 3'b100, 32'h0000_00BB, 2, 1, 4'b1111, 32'h0,        2);
        issue(0, 1, 2'b00, 2'b01, 32'h0000_2002, 32'h1234_5678, 0, 3'b000, 32'h0,        0, 1, 4'b0011, 32'h5678_5678, 2);
        issue(1, 0, 2'b00, 2'b00, 32'h0000_3001, 32'h0,        0, 3'b010, 32'h0,        1, 0, 4'b0000, 32'h0,        0);
        issue(1, 0, 2'b00, 2'b00, 32'h0000_5000, 32'h0,       -1, 3'b001, 32'h0,        5, 0, 4'b0000, 32'h0,        5);
        issue(1, 0, 2'b01, 2'b00, 32'h0000_0002, 32'h0,        1, 3'b100, 32'h0000_CCDD, 3, 1, 4'b1111, 32'h0,        3);
        issue(1, 0, 2'b10, 2'b00, 32'h0000_0003, 32'h0,        0, 3'b100, 32'h0000_00DD, 2, 1, 4'b1111, 32'h0,        2);
        issue(1, 0, 2'b10, 2'b00, 32'h0000_0000, 32'h0,        0, 3'b100, 32'h0000_00AA, 2, 1, 4'b1111, 32'h0,        2);
        issue(1, 0, 2'b11, 2'b00, 32'h0000_4000, 32'h0,        0, 3'b100, 32'hAABB_CCDD, 2, 1, 4'b1111, 32'h0,        2);
        issue(0, 1, 2'b00, 2'b00, 32'h0000_7003, 32'h0000_00EE, 0, 3'b000, 32'h0,        0, 1, 4'b0001, 32'hEEEE_EEEE, 2);
        issue(0, 1, 2'b00, 2'b00, 32'h0000_7000, 32'h0000_0012, 0, 3'b000, 32'h0,        0, 1, 4'b1000, 32'h1212_1212, 2);
        issue(0, 1, 2'b00, 2'b10, 32'h0000_8004, 32'hDEAD_BEEF, 2, 3'b000, 32'h0,        0, 1, 4'b1111, 32'hDEAD_BEEF, 4);
        issue(1, 0, 2'b01, 2'b00, 32'h0000_0001, 32'h0,        0, 3'b010, 32'h0,        1, 0, 4'b0000, 32'h0,        0);
        issue(0, 1, 2'b00, 2'b01, 32'h0000_0003, 32'h0,        0, 3'b010, 32'h0,        1, 0, 4'b0000, 32'h0,        0);
        issue(0, 1, 2'b00, 2'b11, 32'h0000_0006, 32'h0,        0, 3'b010, 32'h0,        1, 0, 4'b0000, 32'h0,        0);
        issue(1, 1, 2'b00, 2'b11, 32'h0000_9000, 32'h0102_0304, 0, 3'b000, 32'h0,        0, 1, 4'b1111, 32'h0102_0304, 2);

        // Reset in the 3rd ACCESS cycle of a never-acked lw.
        @(posedge clk);
        #1;
        ls_valid = 1'b1; ls_memread = 1'b1; ls_memwrite = 1'b0;
        ls_loadsig = 2'b00; ls_addr = 32'h0000_5000; ack_wait = -1;
        @(posedge clk);
        #1;
        ls_valid = 1'b0; ls_memread = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_req", {31'b0, mem_req}, 32'h0);
        chk("async_rst_stall", {31'b0, ls_stall}, 32'h0);
        chk("async_rst_pulses", {29'b0, ls_rvalid, ls_misalign, ls_err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(1, 0, 2'b01, 2'b00, 32'h0000_0000, 32'h0, 0, 3'b100, 32'h0000_AABB, 2, 1, 4'b1111, 32'h0, 2);

        repeat (8) @(posedge clk);
        chk("resp_queue_empty", resp_q.size(), 32'h0);
        chk("bus_queue_empty", bus_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
